// File: rtl/sized_data_memory.sv
// rtl/sized_data_memory.sv - byte-addressable data memory with sized, extended, registered loads
//
// Purpose: 2**N words of W bits with little-endian byte lanes. Accepts byte, half,
// word and (W=64 only) double accesses. Loads are registered and sign- or zero-extended.
// Misaligned and out-of-range accesses are rejected with a one-cycle error pulse.
// After reset the whole array is swept to zero, one word per cycle, while busy is high.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-low reset
//   address      in   W   byte address
//   MemRead      in   1   read request
//   MemWrite     in   1   write request
//   size         in   2   00 byte, 01 half, 10 word, 11 double
//   is_unsigned  in   1   1 zero-extends loads, 0 sign-extends
//   write_data   in   W   store data, LSB-justified
//   read_data    out  W   registered load result
//   read_valid   out  1   pulse, read_data valid
//   busy         out  1   high during the clear sweep
//   err_misalign out  1   pulse, misaligned access rejected
//   err_range    out  1   pulse, out-of-range access rejected

module sized_data_memory #(
  parameter int W = 32,
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] address,
  input  logic         MemRead,
  input  logic         MemWrite,
  input  logic [1:0]   size,
  input  logic         is_unsigned,
  input  logic [W-1:0] write_data,
  output logic [W-1:0] read_data,
  output logic         read_valid,
  output logic         busy,
  output logic         err_misalign,
  output logic         err_range
);

  localparam int NB    = W / 8;
  localparam int L     = $clog2(NB);
  localparam int DEPTH = 2 ** N;

  typedef enum logic {INIT, READY} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] ptr_q, ptr_d;
  logic [W-1:0] read_data_q, read_data_d;
  logic         read_valid_q, read_valid_d;
  logic         err_mis_q, err_mis_d;
  logic         err_rng_q, err_rng_d;

  logic [W-1:0] mem [DEPTH];

  logic [N-1:0] idx;
  logic [L-1:0] off;
  logic         mis;
  logic         rng;
  logic         req;
  logic         acc;
  logic [W-1:0] word_rd;
  logic [W-1:0] shifted;
  logic [W-1:0] load_val;
  logic [W-1:0] bit_mask;
  logic [W-1:0] wdata_sh;

  logic         mem_we;
  logic [N-1:0] mem_wa;
  logic [W-1:0] mem_wd;

  assign idx     = address[N+L-1:L];
  assign off     = address[L-1:0];
  assign rng     = |(address >> (N + L));
  assign req     = MemRead | MemWrite;
  assign acc     = ~mis & ~rng;
  assign word_rd = mem[idx];

  // Alignment: the low address bits covered by the access size must be zero.
  always_comb begin
    mis = 1'b0;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = address[0];
      2'b10:   mis = |address[1:0];
      default: mis = (W == 32) ? 1'b1 : |address[2:0];
    endcase
  end

  // Lane mask for stores: bytes [off, off + 2**size) of the word.
  always_comb begin
    int nbytes;
    int offi;
    bit_mask = '0;
    nbytes   = 1 << size;
    offi     = int'(off);
    for (int i = 0; i < NB; i++) begin
      if ((i >= offi) && (i < offi + nbytes)) begin
        bit_mask[i*8 +: 8] = 8'hFF;
      end
    end
  end

  assign wdata_sh = write_data << {off, 3'b000};
  assign shifted  = word_rd >> {off, 3'b000};

  // Extension: a size cast of a signed slice sign-extends, of an unsigned one zero-extends.
  always_comb begin
    load_val = shifted;
    case (size)
      2'b00:   load_val = is_unsigned ? W'(shifted[7:0])  : W'($signed(shifted[7:0]));
      2'b01:   load_val = is_unsigned ? W'(shifted[15:0]) : W'($signed(shifted[15:0]));
      2'b10:   load_val = is_unsigned ? W'(shifted[31:0]) : W'($signed(shifted[31:0]));
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    err_mis_d    = 1'b0;
    err_rng_d    = 1'b0;
    mem_we       = 1'b0;
    mem_wa       = idx;
    mem_wd       = '0;
    case (state_q)
      INIT: begin
        mem_we = 1'b1;
        mem_wa = ptr_q;
        mem_wd = '0;
        if (ptr_q == N'(DEPTH - 1)) begin
          state_d = READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        if (MemRead) begin
          read_valid_d = 1'b1;
          read_data_d  = acc ? load_val : '0;
        end
        err_mis_d = req & mis;
        err_rng_d = req & ~mis & rng;
        mem_we    = MemWrite & acc;
        // Merge uses the pre-write word, so a same-cycle read sees old contents.
        mem_wd    = (word_rd & ~bit_mask) | (wdata_sh & bit_mask);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= INIT;
      ptr_q        <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      err_mis_q    <= 1'b0;
      err_rng_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      err_mis_q    <= err_mis_d;
      err_rng_q    <= err_rng_d;
    end
  end

  // Array has no reset; rst gates the enable so an edge inside reset never writes.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  assign read_data    = read_data_q;
  assign read_valid   = read_valid_q;
  assign busy         = (state_q == INIT);
  assign err_misalign = err_mis_q;
  assign err_range    = err_rng_q;

endmodule
